fetch_unit: RTL

Parametrised instruction-fetch front end for the pipelined CPU. It replaces the bare PC + adder + single IF/ID register with a program counter, a request/acknowledge port to a variable-latency instruction memory, and a DEPTH-entry prefetch queue feeding decode. Decode stalls through `inst_ready_i`. Branch/jump redirects flush the queue and any in-flight fetch. Each entry carries the instruction and its PC+4 for branch-target computation downstream.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
// Contents: FSM state enum, instruction size, default-width queue entry,
//           occupancy counter width helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam int INST_BYTES = 4;

    // Queue entry at the default 32-bit widths; fetch_unit re-declares the
    // same layout at its own parameter widths.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_plus4;
    } fetch_entry_t;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry FIFO with registered storage and flush.
// Latency: a push at edge t is visible at head_dat_o right after edge t.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
// Ports: push_i/push_dat_i write, pop_i advances head, flush_i empties
//        (wins over push/pop), head_dat_o is the oldest entry, count_o occupancy.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          push_dat_i,
    input  logic                      pop_i,
    output logic [WIDTH-1:0]          head_dat_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q;
    logic [PW-1:0]    wr_q;
    logic [CW-1:0]    cnt_q;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_dat_i;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + PW'(1);
            end
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_dat_o = mem_q[rd_q];
    assign count_o    = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, one-outstanding imem request port, prefetch queue to decode.
// Latency: ack at edge t into an empty queue shows inst_valid_o after edge t; 1 inst/cycle with 1-cycle memory.
// Backpressure: inst_ready_i low stalls the head; requests stop once queue plus in-flight would exceed DEPTH.
// Ports: clk_i/rst_i (sync, active-high), start_i fetch enable, imem_* memory port,
//        redirect_i/redirect_pc_i flush and refetch, inst_* / pc_plus4_o / count_o queue head to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    output logic                    imem_req_o,
    output logic [ADDR_W-1:0]       imem_addr_o,
    input  logic                    imem_ack_i,
    input  logic [DATA_W-1:0]       imem_data_i,
    input  logic                    redirect_i,
    input  logic [ADDR_W-1:0]       redirect_pc_i,
    output logic                    inst_valid_o,
    output logic [DATA_W-1:0]       inst_o,
    output logic [ADDR_W-1:0]       pc_plus4_o,
    input  logic                    inst_ready_i,
    output logic [cnt_w(DEPTH)-1:0] count_o
);
    localparam int            CW      = cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] inst;
        logic [ADDR_W-1:0] pc_plus4;
    } entry_t;

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] redir_pc;
    logic              req_q;
    logic              push;
    logic              pop;
    logic              done;
    logic              issue;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nx;
    entry_t            push_ent;
    entry_t            head_ent;

    assign pc_inc   = pc_q + ADDR_W'(INST_BYTES);
    assign redir_pc = redirect_pc_i & ~ADDR_W'(3);

    // Redirect outranks both queue operations in the same cycle.
    assign pop      = (count != '0) && inst_ready_i && !redirect_i;
    assign push     = (state_q == REQ) && imem_ack_i && !redirect_i;
    assign count_nx = redirect_i ? '0 : count + CW'(push) - CW'(pop);

    // No request is left outstanding after this edge: either we were idle or
    // the current one (real or discarded) completes now.
    assign done  = (state_q == IDLE) || imem_ack_i;
    // count_nx already includes this cycle's push, so the queue cannot overflow.
    assign issue = start_i && (count_nx < DEPTH_C);

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redir_pc;
        end else if (push) begin
            pc_d = pc_inc;
        end
    end

    assign push_ent = '{inst: imem_data_i, pc_plus4: pc_inc};

    // addr_q only follows pc when a new request can start; while a redirected
    // request is still in flight it keeps the address the memory is serving.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (done) begin
                state_q <= issue ? REQ : IDLE;
                req_q   <= issue;
                addr_q  <= pc_d;
            end else if (redirect_i) begin
                state_q <= DISCARD;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + ADDR_W)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (redirect_i),
        .push_i     (push),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .head_dat_o (head_ent),
        .count_o    (count)
    );

    assign imem_req_o   = req_q;
    assign imem_addr_o  = addr_q;
    assign inst_valid_o = (count != '0);
    assign inst_o       = head_ent.inst;
    assign pc_plus4_o   = head_ent.pc_plus4;
    assign count_o      = count;

endmodule
